// File: rtl/kmeans_apb_regfile_pkg.sv
// Shared constants and types for the Kmeans APB register front-end:
// address map, CTRL/STATUS bit positions, and the bus controller states.
package kmeans_pkg;

    localparam int unsigned CENT_BASE   = 32'h000;
    localparam int unsigned CTRL_ADDR   = 32'h008;
    localparam int unsigned STATUS_ADDR = 32'h009;
    localparam int unsigned RAM_BASE    = 32'h010;

    localparam int unsigned CTRL_START   = 0;
    localparam int unsigned CTRL_IRQ_CLR = 1;
    localparam int unsigned CTRL_IRQ_EN  = 2;
    localparam int unsigned CTRL_CNT_LSB = 3;

    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_PENDING = 1;
    localparam int unsigned STAT_IRQ_EN  = 2;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, STALL} apb_state_t;

    typedef enum logic [2:0] {REG_CENT, REG_CTRL, REG_STATUS, REG_RSVD, REG_RAM} region_t;

    // The centroid window ends where CTRL begins; everything from ram_lo up is point RAM.
    function automatic region_t region_of(input int unsigned a, input int unsigned ram_lo);
        if (a < CTRL_ADDR)    return REG_CENT;
        if (a == CTRL_ADDR)   return REG_CTRL;
        if (a == STATUS_ADDR) return REG_STATUS;
        if (a >= ram_lo)      return REG_RAM;
        return REG_RSVD;
    endfunction

endpackage

// File: rtl/kmeans_apb_regfile_if.sv
// Host-side APB signal bundle for the Kmeans register file, including the
// level interrupt that travels with the bus.
interface kmeans_apb_regfile_if #(
    parameter int addrWidth = 9,
    parameter int dataWidth = 91
);
    logic                 psel;
    logic                 penable;
    logic                 pwrite;
    logic [addrWidth-1:0] paddr;
    logic [dataWidth-1:0] pwdata;
    logic [dataWidth-1:0] prdata;
    logic                 pready;
    logic                 interupt;

    modport master (output psel, penable, pwrite, paddr, pwdata,
                    input  prdata, pready, interupt);
    modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                    output prdata, pready, interupt);
endinterface

// File: rtl/kmeans_apb_regfile_fsm.sv
// APB transfer controller: recognises the setup phase, drives a registered
// pready (zero wait states unless stalled) and flags the completion cycle.
module kmeans_apb_fsm
    import kmeans_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic psel,
    input  logic penable,
    input  logic stallable,   // decoded transfer is a CENT/RAM write
    input  logic wait_req,    // engine is still busy after this edge
    output logic pready,
    output logic setup_stb,   // setup phase seen: capture decode now
    output logic done_stb     // transfer completes on this edge
);

    apb_state_t state;

    assign setup_stb = (state == IDLE) && psel && !penable;
    assign done_stb  = pready && psel && penable;

    // NOTE: state and pready use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (psel && !penable) begin
                        if (stallable && wait_req) begin
                            state  <= STALL;
                            pready <= 1'b0;
                        end else begin
                            state  <= ACCESS;
                            pready <= 1'b1;
                        end
                    end
                end
                ACCESS, STALL: begin
                    if (!psel || done_stb) begin
                        state  <= IDLE;
                        pready <= 1'b0;
                    end else if (state == STALL && !wait_req) begin
                        state  <= ACCESS;
                        pready <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    pready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/kmeans_apb_regfile.sv
// APB register file for the Kmeans accelerator: centroid and control
// registers, point-RAM write forwarding, engine start/done handshake.
module kmeans_apb_regfile
    import kmeans_pkg::*;
#(
    parameter int addrWidth         = 9,
    parameter int dataWidth         = 91,
    parameter int centroid_num      = 8,
    parameter int log2_cent_num     = 3,
    parameter int log2_of_point_cnt = 9,
    parameter int ram_base          = RAM_BASE
)(
    input  logic                              clk,
    input  logic                              rst_n,
    kmeans_apb_regfile_if.slave               apb,
    output logic                              start,
    output logic [log2_of_point_cnt-1:0]      point_cnt,
    output logic [centroid_num*dataWidth-1:0] cent_flat,
    output logic                              ram_we,
    output logic [log2_of_point_cnt-1:0]      ram_addr,
    output logic [dataWidth-1:0]              ram_wdata,
    input  logic                              eng_done,
    input  logic                              eng_cent_we,
    input  logic [log2_cent_num-1:0]          eng_cent_idx,
    input  logic [dataWidth-1:0]              eng_cent_data
);

    logic [dataWidth-1:0] cent [centroid_num];
    logic busy, pending, irq_en;
    logic busy_d, pending_d, irq_en_d, start_d;

    region_t                      rgn_now, rgn_q;
    logic                         wr_q;
    logic [log2_cent_num-1:0]     idx_q;
    logic [log2_of_point_cnt-1:0] off_q;
    logic [dataWidth-1:0]         rd_now;
    logic setup_stb, done_stb, stallable, wait_req;
    logic cent_wr, ctrl_wr, ram_wr;

    assign rgn_now   = region_of(32'(apb.paddr), 32'(ram_base));
    assign stallable = apb.pwrite && (rgn_now == REG_CENT || rgn_now == REG_RAM);
    assign wait_req  = busy && !eng_done;

    kmeans_apb_fsm u_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .psel      (apb.psel),
        .penable   (apb.penable),
        .stallable (stallable),
        .wait_req  (wait_req),
        .pready    (apb.pready),
        .setup_stb (setup_stb),
        .done_stb  (done_stb)
    );

    assign cent_wr = done_stb && wr_q && rgn_q == REG_CENT;
    assign ctrl_wr = done_stb && wr_q && rgn_q == REG_CTRL;
    assign ram_wr  = done_stb && wr_q && rgn_q == REG_RAM;

    for (genvar g = 0; g < centroid_num; g++) begin : g_flat
        assign cent_flat[g*dataWidth +: dataWidth] = cent[g];
    end

    // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
    always_comb begin
        rd_now = '0;
        case (rgn_now)
            REG_CENT:   rd_now = cent[apb.paddr[log2_cent_num-1:0]];
            REG_CTRL: begin
                rd_now[CTRL_IRQ_EN]                        = irq_en;
                rd_now[CTRL_CNT_LSB +: log2_of_point_cnt] = point_cnt;
            end
            REG_STATUS: begin
                rd_now[STAT_BUSY]    = busy;
                rd_now[STAT_PENDING] = pending;
                rd_now[STAT_IRQ_EN]  = irq_en;
            end
            default: ;
        endcase
    end

    // Engine done is applied last to pending so it beats a simultaneous IRQ_CLR.
    always_comb begin
        busy_d    = busy;
        pending_d = pending;
        irq_en_d  = irq_en;
        start_d   = 1'b0;
        if (eng_done) busy_d = 1'b0;
        if (ctrl_wr) begin
            irq_en_d = apb.pwdata[CTRL_IRQ_EN];
            if (apb.pwdata[CTRL_IRQ_CLR]) pending_d = 1'b0;
            if (apb.pwdata[CTRL_START] && !busy) begin
                start_d = 1'b1;
                busy_d  = 1'b1;
            end
        end
        if (eng_done) pending_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the centroid array is reset explicitly; it must read as zero after reset.
            for (int i = 0; i < centroid_num; i++) cent[i] <= '0;
            rgn_q        <= REG_RSVD;
            wr_q         <= 1'b0;
            idx_q        <= '0;
            off_q        <= '0;
            apb.prdata   <= '0;
            apb.interupt <= 1'b0;
            busy         <= 1'b0;
            pending      <= 1'b0;
            irq_en       <= 1'b0;
            start        <= 1'b0;
            point_cnt    <= '0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
        end else begin
            busy         <= busy_d;
            pending      <= pending_d;
            irq_en       <= irq_en_d;
            start        <= start_d;
            apb.interupt <= pending_d && irq_en_d;

            if (setup_stb) begin
                rgn_q      <= rgn_now;
                wr_q       <= apb.pwrite;
                idx_q      <= apb.paddr[log2_cent_num-1:0];
                off_q      <= log2_of_point_cnt'(apb.paddr - addrWidth'(ram_base));
                apb.prdata <= apb.pwrite ? '0 : rd_now;
            end

            if (ctrl_wr) point_cnt <= apb.pwdata[CTRL_CNT_LSB +: log2_of_point_cnt];

            ram_we <= ram_wr;
            if (ram_wr) begin
                ram_addr  <= off_q;
                ram_wdata <= apb.pwdata;
            end

            // Engine write-back is last so it wins over a same-edge host write.
            if (cent_wr)     cent[idx_q]        <= apb.pwdata;
            if (eng_cent_we) cent[eng_cent_idx] <= eng_cent_data;
        end
    end

endmodule

// File: tb/tb_kmeans_apb_regfile.sv
// Directed bench for kmeans_apb_regfile: a register-map model checked every
// cycle plus hand-computed literal expectations for each scenario.
module tb_kmeans_apb_regfile;

    localparam int AW = 9;
    localparam int DW = 91;
    localparam int CN = 8;
    localparam int FW = CN * DW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic          start;
    logic [8:0]    point_cnt;
    logic [FW-1:0] cent_flat;
    logic          ram_we;
    logic [8:0]    ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          eng_done = 1'b0;
    logic          eng_cent_we = 1'b0;
    logic [2:0]    eng_cent_idx = '0;
    logic [DW-1:0] eng_cent_data = '0;

    kmeans_apb_regfile_if #(.addrWidth(AW), .dataWidth(DW)) bus ();

    kmeans_apb_regfile dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .apb           (bus),
        .start         (start),
        .point_cnt     (point_cnt),
        .cent_flat     (cent_flat),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .eng_done      (eng_done),
        .eng_cent_we   (eng_cent_we),
        .eng_cent_idx  (eng_cent_idx),
        .eng_cent_data (eng_cent_data)
    );

    always #5 clk = ~clk;

    // Register-map model: what the host-visible state must be right now.
    logic [DW-1:0] m_cent [CN];
    logic [8:0]    m_cnt;
    logic          m_busy, m_pending, m_irq_en;
    logic          m_start, m_ram_we;
    logic [8:0]    m_ram_addr;
    logic [DW-1:0] m_ram_data;
    bit            chk_en = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        else             n_pass++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < CN; i++) m_cent[i] = '0;
        m_cnt = '0; m_busy = 0; m_pending = 0; m_irq_en = 0;
        m_start = 0; m_ram_we = 0; m_ram_addr = '0; m_ram_data = '0;
    endtask

    function automatic logic [FW-1:0] model_flat();
        logic [FW-1:0] f;
        for (int i = 0; i < CN; i++) f[i*DW +: DW] = m_cent[i];
        return f;
    endfunction

    function automatic logic [DW-1:0] model_read(input logic [8:0] a);
        logic [DW-1:0] r;
        r = '0;
        if (a < 9'd8) r = m_cent[a[2:0]];
        else if (a == 9'd8) begin r[2] = m_irq_en; r[11:3] = m_cnt; end
        else if (a == 9'd9) r = {88'd0, m_irq_en, m_pending, m_busy};
        return r;
    endfunction

    // Applied on the completion edge of a host write.
    task automatic model_write(input logic [8:0] a, input logic [DW-1:0] d);
        if (a < 9'd8) m_cent[a[2:0]] = d;
        else if (a == 9'd8) begin
            m_irq_en = d[2];
            m_cnt    = d[11:3];
            if (d[1] && !eng_done) m_pending = 0;
            if (d[0] && !m_busy) begin m_busy = 1; m_start = 1; end
        end else if (a >= 9'd16) begin
            m_ram_we = 1; m_ram_addr = a - 9'd16; m_ram_data = d;
        end
    endtask

    task automatic apb_xfer(input bit wr, input logic [8:0] a, input logic [DW-1:0] d,
                            input int exp_waits, output logic [DW-1:0] rd);
        logic [DW-1:0] exp_rd;
        int  waits;
        bit  got;
        @(negedge clk);
        bus.psel = 1; bus.penable = 0; bus.pwrite = wr; bus.paddr = a; bus.pwdata = d;
        exp_rd = model_read(a);
        @(negedge clk);
        bus.penable = 1;
        waits = 0; got = 0;
        for (int n = 0; n < 64 && !got; n++) begin
            if (bus.pready) got = 1;
            else begin waits++; @(negedge clk); end
        end
        check("pready timeout", got, 1'b1);
        check("wait states", waits, exp_waits);
        rd = bus.prdata;
        if (!wr) check("prdata", rd, exp_rd);
        if (got) begin
            @(posedge clk);
            if (wr) model_write(a, d);
            #1;
        end
        bus.psel = 0; bus.penable = 0;
    endtask

    task automatic eng_pulse();
        @(negedge clk); eng_done = 1;
        @(posedge clk); m_busy = 0; m_pending = 1;
        #1 eng_done = 0;
    endtask

    task automatic eng_write(input logic [2:0] idx, input logic [DW-1:0] d);
        @(negedge clk); eng_cent_we = 1; eng_cent_idx = idx; eng_cent_data = d;
        @(posedge clk); m_cent[idx] = d;
        #1 eng_cent_we = 0;
    endtask

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("cent_flat", cent_flat, model_flat());
            check("point_cnt", point_cnt, m_cnt);
            check("interupt", bus.interupt, m_pending & m_irq_en);
            check("start", start, m_start);
            check("ram_we", ram_we, m_ram_we);
            if (m_ram_we) begin
                check("ram_addr", ram_addr, m_ram_addr);
                check("ram_wdata", ram_wdata, m_ram_data);
            end
            m_start  = 0;
            m_ram_we = 0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] rd;
        logic [DW-1:0] d_pat, e_pat;
        d_pat = 91'h123_4567_89AB_CDEF_0123;
        e_pat = 91'h7FF_FFFF_FFFF_FFFF_FFFF_FFFF;
        bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = '0; bus.pwdata = '0;
        model_reset();

        #12;
        check("rst prdata", bus.prdata, 0);
        check("rst pready", bus.pready, 0);
        check("rst interupt", bus.interupt, 0);
        check("rst start", start, 0);
        check("rst cent_flat", cent_flat, 0);
        check("rst ram_we", ram_we, 0);
        @(negedge clk); rst_n = 1; chk_en = 1;

        // Centroid write/readback and boundary entries of the window
        apb_xfer(1, 9'h003, 91'h1_2345, 0, rd);
        apb_xfer(0, 9'h003, '0, 0, rd);
        check("cent3 read", rd, 91'h1_2345);
        check("cent3 slice", cent_flat[3*DW +: DW], 91'h1_2345);
        apb_xfer(1, 9'h007, e_pat, 0, rd);
        apb_xfer(0, 9'h007, '0, 0, rd);
        check("cent7 read", rd, e_pat);
        apb_xfer(1, 9'h00F, d_pat, 0, rd);
        apb_xfer(0, 9'h00A, '0, 0, rd);
        check("reserved read", rd, 0);
        apb_xfer(0, 9'h020, '0, 0, rd);
        check("ram read", rd, 0);

        // Point-RAM window ends
        apb_xfer(1, 9'h010, d_pat, 0, rd);
        @(negedge clk);
        check("ram0 we", ram_we, 1);
        check("ram0 addr", ram_addr, 9'h000);
        check("ram0 data", ram_wdata, d_pat);
        apb_xfer(1, 9'h1FF, e_pat, 0, rd);
        @(negedge clk);
        check("ram1 addr", ram_addr, 9'h1EF);
        check("ram1 data", ram_wdata, e_pat);

        // START + irq_en + point_cnt=100
        apb_xfer(1, 9'h008, 91'd805, 0, rd);
        @(negedge clk);
        check("start pulse", start, 1);
        check("point_cnt 100", point_cnt, 9'd100);
        @(negedge clk);
        check("start one cycle", start, 0);
        apb_xfer(0, 9'h009, '0, 0, rd);
        check("status busy", rd, 91'd5);
        apb_xfer(0, 9'h008, '0, 0, rd);
        check("ctrl read", rd, 91'd804);

        // Second START while busy: no pulse, no stall
        apb_xfer(1, 9'h008, 91'd805, 0, rd);
        @(negedge clk);
        check("no 2nd start", start, 0);

        // CENT write while busy stalls until the cycle after eng_done
        fork
            apb_xfer(1, 9'h000, d_pat, 2, rd);
            begin repeat (2) @(negedge clk); eng_pulse(); end
        join
        @(negedge clk);
        check("irq raised", bus.interupt, 1);
        check("stalled cent0", cent_flat[DW-1:0], d_pat);
        apb_xfer(0, 9'h009, '0, 0, rd);
        check("status done", rd, 91'd6);

        apb_xfer(1, 9'h008, 91'd806, 0, rd);
        @(negedge clk);
        check("irq cleared", bus.interupt, 0);

        // eng_done and IRQ_CLR on the same edge: set wins
        apb_xfer(1, 9'h008, 91'd805, 0, rd);
        fork
            apb_xfer(1, 9'h008, 91'd806, 0, rd);
            begin @(negedge clk); eng_pulse(); end
        join
        @(negedge clk);
        check("set wins irq", bus.interupt, 1);
        apb_xfer(0, 9'h009, '0, 0, rd);
        check("set wins status", rd, 91'd6);

        eng_write(3'd5, 91'hABCDE);
        apb_xfer(0, 9'h005, '0, 0, rd);
        check("eng cent5", rd, 91'hABCDE);

        // Reset in the middle of a stalled transfer
        apb_xfer(1, 9'h008, 91'd805, 0, rd);
        @(negedge clk);
        bus.psel = 1; bus.penable = 0; bus.pwrite = 1; bus.paddr = 9'h001; bus.pwdata = d_pat;
        @(negedge clk); bus.penable = 1;
        @(negedge clk);
        check("stall pready", bus.pready, 0);
        #2 rst_n = 0;
        model_reset();
        #1;
        check("mid rst prdata", bus.prdata, 0);
        check("mid rst pready", bus.pready, 0);
        check("mid rst interupt", bus.interupt, 0);
        check("mid rst start", start, 0);
        check("mid rst cent_flat", cent_flat, 0);
        check("mid rst point_cnt", point_cnt, 0);
        bus.psel = 0; bus.penable = 0;
        @(negedge clk); rst_n = 1;
        @(negedge clk);
        check("post rst pready", bus.pready, 0);
        apb_xfer(0, 9'h009, '0, 0, rd);
        check("post rst status", rd, 0);
        apb_xfer(0, 9'h003, '0, 0, rd);
        check("post rst cent3", rd, 0);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
